// File: rtl/lfsr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl_if
// Description : Host-side control/config bundle and datapath opcode outputs
//               of the LFSR pattern sequencer. The host drives the master
//               side; the sequencer is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_seq_ctrl_if #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 8
);
    // Host controls and configuration
    logic              start;
    logic              abort;
    logic [6:0]        cfg_taps;
    logic [7:0]        cfg_seed;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_stride;
    logic [CNT_W-1:0]  cfg_count;

    // Datapath opcode stream and status
    logic [5:0]        op;
    logic [6:0]        op_taps;
    logic [7:0]        op_seed;
    logic [ADDR_W-1:0] op_addr;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              err_zero;
    logic [CNT_W-1:0]  pat_cnt;

    modport master (
        output start, abort, cfg_taps, cfg_seed, cfg_base, cfg_stride, cfg_count,
        input  op, op_taps, op_seed, op_addr, mem_we, busy, done, err_zero, pat_cnt
    );

    modport slave (
        input  start, abort, cfg_taps, cfg_seed, cfg_base, cfg_stride, cfg_count,
        output op, op_taps, op_seed, op_addr, mem_we, busy, done, err_zero, pat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Sequencer for the LFSR pattern datapath. On start it issues
//               CONFIG, INIT, INIT_ADDR, then N x (RUN, ST_M_L[, ST_M_HD],
//               ADD_ADDR) and finally a one-cycle done in HALT.
//               Optional feature macro: LFSR_SEQ_HD_STORE_EN adds the STHD
//               state (ST_M_HD store of the Hamming distance) after STORE.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    lfsr_seq_ctrl_if.slave      ctrl
);

    localparam logic [5:0] C_OP_HALT      = 6'h00;
    localparam logic [5:0] C_OP_CONFIG    = 6'h01;
    localparam logic [5:0] C_OP_INIT      = 6'h02;
    localparam logic [5:0] C_OP_RUN       = 6'h03;
    localparam logic [5:0] C_OP_ST_M_L    = 6'h04;
    localparam logic [5:0] C_OP_INIT_ADDR = 6'h06;
    localparam logic [5:0] C_OP_ADD_ADDR  = 6'h07;
`ifdef LFSR_SEQ_HD_STORE_EN
    localparam logic [5:0] C_OP_ST_M_HD   = 6'h08;
`endif

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CFG   = 4'd1,
        ST_SEED  = 4'd2,
        ST_ADDR  = 4'd3,
        ST_RUN   = 4'd4,
        ST_STORE = 4'd5,
`ifdef LFSR_SEQ_HD_STORE_EN
        ST_STHD  = 4'd6,
`endif
        ST_ADV   = 4'd7,
        ST_DONE  = 4'd8,
        ST_ERR   = 4'd9
    } state_t;

    state_t            state_q,    state_d;
    logic [6:0]        taps_q,     taps_d;
    logic [7:0]        seed_q,     seed_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [ADDR_W-1:0] stride_q,   stride_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [CNT_W-1:0]  pat_cnt_q,  pat_cnt_d;
    logic              err_zero_q, err_zero_d;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic [5:0]        w_op;
    logic [6:0]        w_op_taps;
    logic [7:0]        w_op_seed;
    logic [ADDR_W-1:0] w_op_addr;
    logic              w_mem_we;
    logic              w_done;

    // pat_cnt stops at count, so this never wraps even when count is all ones
    assign w_cnt_inc = pat_cnt_q + CNT_W'(1);

    // State, shadow configuration and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            taps_q     <= '0;
            seed_q     <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            pat_cnt_q  <= '0;
            err_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            taps_q     <= taps_d;
            seed_q     <= seed_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            count_q    <= count_d;
            pat_cnt_q  <= pat_cnt_d;
            err_zero_q <= err_zero_d;
        end
    end

    // Next-state logic; abort outranks every other transition outside IDLE
    always_comb begin
        state_d    = state_q;
        taps_d     = taps_q;
        seed_d     = seed_q;
        base_d     = base_q;
        stride_d   = stride_q;
        count_d    = count_q;
        pat_cnt_d  = pat_cnt_q;
        err_zero_d = err_zero_q;

        if ((state_q != ST_IDLE) && ctrl.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        taps_d     = ctrl.cfg_taps;
                        seed_d     = ctrl.cfg_seed;
                        base_d     = ctrl.cfg_base;
                        stride_d   = ctrl.cfg_stride;
                        count_d    = ctrl.cfg_count;
                        pat_cnt_d  = '0;
                        err_zero_d = (ctrl.cfg_seed == 8'h00);
                        state_d    = (ctrl.cfg_seed == 8'h00) ? ST_ERR : ST_CFG;
                    end
                end
                ST_CFG:   state_d = ST_SEED;
                ST_SEED:  state_d = ST_ADDR;
                ST_ADDR:  state_d = (count_q == '0) ? ST_DONE : ST_RUN;
                ST_RUN:   state_d = ST_STORE;
                ST_STORE: begin
`ifdef LFSR_SEQ_HD_STORE_EN
                    state_d = ST_STHD;
`else
                    state_d = ST_ADV;
`endif
                end
`ifdef LFSR_SEQ_HD_STORE_EN
                ST_STHD:  state_d = ST_ADV;
`endif
                ST_ADV: begin
                    pat_cnt_d = w_cnt_inc;
                    state_d   = (w_cnt_inc == count_q) ? ST_DONE : ST_RUN;
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ERR:   state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Opcode and strobes decoded purely from registered state
    always_comb begin
        w_op      = C_OP_HALT;
        w_op_taps = '0;
        w_op_seed = '0;
        w_op_addr = '0;
        w_mem_we  = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            ST_CFG: begin
                w_op      = C_OP_CONFIG;
                w_op_taps = taps_q;
            end
            ST_SEED: begin
                w_op      = C_OP_INIT;
                w_op_seed = seed_q;
            end
            ST_ADDR: begin
                w_op      = C_OP_INIT_ADDR;
                w_op_addr = base_q;
            end
            ST_RUN:   w_op = C_OP_RUN;
            ST_STORE: begin
                w_op     = C_OP_ST_M_L;
                w_mem_we = 1'b1;
            end
`ifdef LFSR_SEQ_HD_STORE_EN
            ST_STHD: begin
                w_op     = C_OP_ST_M_HD;
                w_mem_we = 1'b1;
            end
`endif
            ST_ADV: begin
                w_op      = C_OP_ADD_ADDR;
                w_op_addr = stride_q;
            end
            ST_DONE:  w_done = 1'b1;
            default:  w_op = C_OP_HALT;
        endcase
    end

    assign ctrl.op       = w_op;
    assign ctrl.op_taps  = w_op_taps;
    assign ctrl.op_seed  = w_op_seed;
    assign ctrl.op_addr  = w_op_addr;
    assign ctrl.mem_we   = w_mem_we;
    assign ctrl.busy     = (state_q != ST_IDLE);
    assign ctrl.done     = w_done;
    assign ctrl.err_zero = err_zero_q;
    assign ctrl.pat_cnt  = pat_cnt_q;

endmodule
`default_nettype wire
